// File: rtl/inst_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_fetch : PC owner, single-outstanding imem fetch, FIFO to decode      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module inst_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        is_jmp_i,
   input  logic [31:0] jmp_addr_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o,
   output logic        inst_valid_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t             state_q;
   logic [31:0]        fetch_pc_q;
   logic               imem_req_q;
   logic [31:0]        imem_addr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic [CNT_W-1:0]   count_d;
   logic [31:0]        pc_mem_q   [FIFO_DEPTH];
   logic [31:0]        inst_mem_q [FIFO_DEPTH];

   logic               empty;
   logic               pop;
   logic               redir;
   logic               ack;
   logic               push;
   logic [31:0]        jmp_pc;

   always_comb begin
      empty   = (count_q == '0);
      pop     = ~empty & ~stall_i;
      redir   = pop & is_jmp_i;
      ack     = imem_ack_i & imem_req_q;
      push    = ack & (state_q == S_WAIT) & ~redir;
      jmp_pc  = {jmp_addr_i[31:2], 2'b00};
      count_d = count_q;
      if (redir) begin
         count_d = '0;
      end else begin
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Issue uses count_q only: a same-cycle pop never frees a slot for issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         fetch_pc_q  <= RESET_PC;
         imem_req_q  <= 1'b0;
         imem_addr_q <= RESET_PC;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (redir) begin
                  fetch_pc_q <= jmp_pc;
               end else if (count_q < DEPTH_C) begin
                  imem_req_q  <= 1'b1;
                  imem_addr_q <= fetch_pc_q;
                  state_q     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (ack) begin
                  imem_req_q <= 1'b0;
                  state_q    <= S_IDLE;
                  fetch_pc_q <= redir ? jmp_pc : fetch_pc_q + 32'd4;
               end else if (redir) begin
                  fetch_pc_q <= jmp_pc;
                  state_q    <= S_DROP;
               end
            end
            S_DROP: begin
               if (redir) begin
                  fetch_pc_q <= jmp_pc;
               end
               if (ack) begin
                  imem_req_q <= 1'b0;
                  state_q    <= S_IDLE;
               end
            end
            default: begin
               imem_req_q <= 1'b0;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (redir) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
         inst_mem_q[wr_ptr_q] <= imem_rdata_i;
      end
   end

   assign imem_req_o   = imem_req_q;
   assign imem_addr_o  = imem_addr_q;
   assign inst_valid_o = ~empty;
   assign inst_o       = empty ? 32'h0000_0000 : inst_mem_q[rd_ptr_q];
   assign pc_o         = empty ? fetch_pc_q : pc_mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_inst_fetch : directed bench for inst_fetch                              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b1;
   logic        is_jmp = 1'b0;
   logic [31:0] jmp_addr = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        inst_valid;

   logic        auto_en = 1'b0;
   logic        man_ack = 1'b0;
   int          lat = 0;
   int          wcnt = 0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   inst_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall_i      (stall),
      .is_jmp_i     (is_jmp),
      .jmp_addr_i   (jmp_addr),
      .imem_req_o   (imem_req),
      .imem_addr_o  (imem_addr),
      .imem_ack_i   (imem_ack),
      .imem_rdata_i (imem_rdata),
      .inst_o       (inst),
      .pc_o         (pc),
      .inst_valid_o (inst_valid)
   );

   // Memory model: returns the address as data, optional fixed ack latency.
   always @(posedge clk) begin
      if (!rst_n || !imem_req || imem_ack) wcnt <= 0;
      else                                wcnt <= wcnt + 1;
   end
   assign imem_ack   = auto_en ? (imem_req && (wcnt >= lat)) : man_ack;
   assign imem_rdata = imem_addr;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input logic aut, input int l);
      rst_n = 1'b0; stall = 1'b1; is_jmp = 1'b0; man_ack = 1'b0;
      auto_en = aut; lat = l;
      repeat (2) @(negedge clk);
      chk_val("rst_req", {31'h0, imem_req}, 32'h0);
      chk_val("rst_addr", imem_addr, 32'h0);
      chk_val("rst_inst", inst, 32'h0);
      chk_val("rst_pc", pc, 32'h0);
      chk_val("rst_valid", {31'h0, inst_valid}, 32'h0);
      rst_n = 1'b1;
   endtask

   task automatic wait_req(input logic [31:0] exp, input string tag);
      int n = 0;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk_val({tag, "_req"}, {31'h0, imem_req}, 32'h1);
      chk_val({tag, "_addr"}, imem_addr, exp);
   endtask

   task automatic ack_cyc();
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
   endtask

   task automatic head(input string tag, input logic v, input logic [31:0] p);
      chk_val({tag, "_valid"}, {31'h0, inst_valid}, {31'h0, v});
      chk_val({tag, "_pc"}, pc, p);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_a, exp_p, a0;
      int          first, nval, n;

      // 1: zero-wait streaming
      do_reset(1'b1, 0);
      stall = 1'b0;
      exp_a = 0; exp_p = 0; first = 0; nval = 0;
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         if (imem_req) begin
            chk_val("t1_addr", imem_addr, exp_a);
            exp_a += 4;
         end
         if (inst_valid) begin
            if (first == 0) first = c;
            chk_val("t1_pc", pc, exp_p);
            chk_val("t1_inst", inst, exp_p);
            exp_p += 4;
            nval++;
         end
      end
      chk_val("t1_first_ge2", {31'h0, first >= 2}, 32'h1);
      chk_val("t1_count_ge5", {31'h0, nval >= 5}, 32'h1);

      // 2: three-cycle ack latency, then 3: stall saturation
      do_reset(1'b1, 3);
      for (int k = 0; k < 2; k++) begin
         a0 = 32'(k * 4);
         wait_req(a0, "t2_issue");
         n = 0;
         while (!imem_ack && n < 10) begin
            chk_val("t2_hold_req", {31'h0, imem_req}, 32'h1);
            chk_val("t2_hold_addr", imem_addr, a0);
            @(negedge clk);
            n++;
         end
         chk_val("t2_lat", 32'(n), 32'd3);
         @(negedge clk);
         head("t2_head", 1'b1, 32'h0);
      end
      lat = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk_val("t3_noreq", {31'h0, imem_req}, 32'h0);
         head("t3_hold", 1'b1, 32'h0);
      end
      stall = 1'b0;
      exp_p = 0; nval = 0;
      for (int c = 0; c < 20; c++) begin
         if (inst_valid) begin
            chk_val("t3_pc", pc, exp_p);
            exp_p += 4;
            nval++;
         end
         @(negedge clk);
      end
      chk_val("t3_count_ge6", {31'h0, nval >= 6}, 32'h1);

      // 4: redirect while fetch of 0x8 is pending
      do_reset(1'b0, 0);
      wait_req(32'h0, "t4_a");
      ack_cyc();
      head("t4_h0", 1'b1, 32'h0);
      wait_req(32'h4, "t4_b");
      man_ack = 1'b1; stall = 1'b0;
      @(negedge clk);
      man_ack = 1'b0; stall = 1'b1;
      head("t4_h4", 1'b1, 32'h4);
      wait_req(32'h8, "t4_c");
      stall = 1'b0; is_jmp = 1'b1; jmp_addr = 32'h0000_0100;
      @(negedge clk);
      stall = 1'b1; is_jmp = 1'b0;
      chk_val("t4_drop_req", {31'h0, imem_req}, 32'h1);
      chk_val("t4_drop_addr", imem_addr, 32'h8);
      head("t4_flush", 1'b0, 32'h100);
      @(negedge clk);
      ack_cyc();
      chk_val("t4_after_req", {31'h0, imem_req}, 32'h0);
      chk_val("t4_discard", {31'h0, inst_valid}, 32'h0);
      wait_req(32'h100, "t4_d");
      ack_cyc();
      head("t4_tgt", 1'b1, 32'h100);
      chk_val("t4_inst", inst, 32'h100);

      // 5: redirect coincident with ack, unaligned target, then pc wrap
      do_reset(1'b0, 0);
      wait_req(32'h0, "t5_a");
      ack_cyc();
      wait_req(32'h4, "t5_b");
      man_ack = 1'b1; stall = 1'b0; is_jmp = 1'b1; jmp_addr = 32'h0000_0203;
      @(negedge clk);
      man_ack = 1'b0; stall = 1'b1; is_jmp = 1'b0;
      head("t5_flush", 1'b0, 32'h200);
      chk_val("t5_req_off", {31'h0, imem_req}, 32'h0);
      wait_req(32'h200, "t5_c");
      ack_cyc();
      head("t5_tgt", 1'b1, 32'h200);
      chk_val("t5_inst", inst, 32'h200);
      wait_req(32'h204, "t5_d");
      stall = 1'b0; is_jmp = 1'b1; jmp_addr = 32'hFFFF_FFFF;
      @(negedge clk);
      stall = 1'b1; is_jmp = 1'b0;
      chk_val("t5_drop_addr", imem_addr, 32'h204);
      ack_cyc();
      chk_val("t5_discard", {31'h0, inst_valid}, 32'h0);
      wait_req(32'hFFFF_FFFC, "t5_e");
      ack_cyc();
      head("t5_top", 1'b1, 32'hFFFF_FFFC);
      wait_req(32'h0, "t5_wrap");

      // 6: asynchronous reset mid-WAIT, late ack ignored
      do_reset(1'b0, 0);
      wait_req(32'h0, "t6_a");
      ack_cyc();
      wait_req(32'h4, "t6_b");
      #2 rst_n = 1'b0;
      #1;
      chk_val("t6_req", {31'h0, imem_req}, 32'h0);
      chk_val("t6_addr", imem_addr, 32'h0);
      chk_val("t6_inst", inst, 32'h0);
      head("t6_rst", 1'b0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1; man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      chk_val("t6_late_ack", {31'h0, inst_valid}, 32'h0);
      wait_req(32'h0, "t6_refetch");
      ack_cyc();
      head("t6_head", 1'b1, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
